// File: rtl/clock_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   state_e   : divider FSM states (IDLE, RUN, DRAIN)
//   MIN_DIV   : smallest divisor the divider accepts
//   clamp_div : raises any requested divisor below MIN_DIV up to MIN_DIV
package clock_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < MIN_DIV) ? 32'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/clock_divider_prog.sv
// Runtime-programmable, glitch-free clock divider.
// Divides clk_in by N (2..2^CNT_W-1). Each period is floor(N/2) cycles high followed by
// N-floor(N/2) cycles low. Divisor changes and stops only take effect at period boundaries.
//   clk_in  : system clock
//   rst_n   : asynchronous active-low reset
//   en      : run request; dropping it finishes the current period before stopping
//   load    : single-cycle strobe capturing div_val
//   div_val : requested divisor
//   clk_out : registered divided clock
//   tick    : one-cycle pulse coincident with each rising edge of clk_out
//   cur_div : divisor of the period currently running
//   running : high in RUN and DRAIN
module clock_divider_prog
  import clock_div_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div,
  output logic             running
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] clamped;
  logic [CNT_W-1:0] next_div;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_inc;
  logic             last;

  assign clamped  = CNT_W'(clamp_div(32'(div_val)));
  // A load on the same edge as a period start takes effect immediately.
  assign next_div = load ? clamped : pend_q;
  assign half     = cur_q >> 1;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign last     = (cnt_q == cur_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    cur_d   = cur_q;
    pend_d  = load ? clamped : pend_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (en) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
          cur_d   = next_div;
        end
      end
      RUN, DRAIN: begin
        if (last) begin
          cnt_d = '0;
          if (state_q == RUN && en) begin
            clk_d  = 1'b1;
            tick_d = 1'b1;
            cur_d  = next_div;
          end else begin
            // DRAIN always ends in IDLE, even if en came back during the drain.
            state_d = IDLE;
            clk_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == half) begin
            clk_d = 1'b0;
          end
          if (state_q == RUN && !en) begin
            state_d = DRAIN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      cur_q   <= CNT_W'(DEFAULT_DIV);
      pend_q  <= CNT_W'(DEFAULT_DIV);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign cur_div = cur_q;
  assign running = (state_q != IDLE);

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: a behavioural period model pushes the expected
// outputs for every clock edge into a scoreboard queue, which is popped and compared on the
// following falling edge. Directed waveform patterns are also compared against constants.
module tb_clock_divider_prog;

  localparam int unsigned CNT_W = 16;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             en;
  logic             load;
  logic [CNT_W-1:0] div_val;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] cur_div;
  logic             running;

  clock_divider_prog #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (en),
    .load   (load),
    .div_val(div_val),
    .clk_out(clk_out),
    .tick   (tick),
    .cur_div(cur_div),
    .running(running)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic             clk_out;
    logic             tick;
    logic             running;
    logic [CNT_W-1:0] cur_div;
  } exp_t;

  exp_t sb_q[$];

  // Model: 0 = idle, 1 = run, 2 = drain; m_pos is the position inside the current period.
  int          m_state;
  int unsigned m_pos;
  int unsigned m_cur;
  int unsigned m_pend;
  bit          m_tick;

  task automatic model_reset();
    m_state = 0;
    m_pos   = 0;
    m_cur   = 4;
    m_pend  = 4;
    m_tick  = 0;
    sb_q.delete();
  endtask

  task automatic model_step(input bit e, input bit l, input logic [CNT_W-1:0] d);
    int unsigned c;
    int unsigned nd;
    exp_t        x;
    c  = (32'(d) < 2) ? 2 : 32'(d);
    nd = l ? c : m_pend;
    if (l) m_pend = c;
    m_tick = 0;
    if (m_state == 0) begin
      if (e) begin
        m_state = 1;
        m_pos   = 0;
        m_cur   = nd;
        m_tick  = 1;
      end
    end else if (m_pos == m_cur - 1) begin
      m_pos = 0;
      if (m_state == 1 && e) begin
        m_cur  = nd;
        m_tick = 1;
      end else begin
        m_state = 0;
      end
    end else begin
      m_pos++;
      if (m_state == 1 && !e) m_state = 2;
    end
    x.clk_out = (m_state != 0) && (m_pos < m_cur / 2);
    x.tick    = m_tick;
    x.running = (m_state != 0);
    x.cur_div = CNT_W'(m_cur);
    sb_q.push_back(x);
  endtask

  always @(negedge clk_in) begin
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      if (rst_n) begin
        check_eq("sb_clk_out", 32'(clk_out), 32'(x.clk_out));
        check_eq("sb_tick", 32'(tick), 32'(x.tick));
        check_eq("sb_running", 32'(running), 32'(x.running));
        check_eq("sb_cur_div", 32'(cur_div), 32'(x.cur_div));
      end
    end
  end

  task automatic cycle(input bit e, input bit l, input logic [CNT_W-1:0] d);
    en      = e;
    load    = l;
    div_val = d;
    model_step(e, l, d);
    @(posedge clk_in);
    #1;
    load = 1'b0;
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) cycle(e, 1'b0, '0);
  endtask

  // n cycles; en taken from en_pat (first cycle = bit n-1); load fires on cycle li.
  task automatic collect(input int n, input logic [31:0] en_pat, input int li,
                         input logic [CNT_W-1:0] d, output logic [31:0] pc,
                         output logic [31:0] pt, output logic [31:0] pr);
    pc = '0;
    pt = '0;
    pr = '0;
    for (int i = 0; i < n; i++) begin
      cycle(en_pat[n-1-i], (i == li), d);
      pc = {pc[30:0], clk_out};
      pt = {pt[30:0], tick};
      pr = {pr[30:0], running};
    end
  endtask

  logic [31:0] pc, pt, pr;

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    div_val = '0;
    model_reset();
    #12;
    check_eq("rst_clk_out", 32'(clk_out), 32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_cur_div", 32'(cur_div), 32'd4);
    rst_n = 1'b1;
    run(3, 1'b0);

    // Default divide-by-4.
    collect(8, '1, -1, '0, pc, pt, pr);
    check_eq("n4_clk", pc, 32'b11001100);
    check_eq("n4_tick", pt, 32'b10001000);
    check_eq("n4_cur_div", 32'(cur_div), 32'd4);

    // Stop at the boundary, load 5 while idle, run.
    run(3, 1'b0);
    cycle(1'b0, 1'b1, 16'd5);
    collect(10, '1, -1, '0, pc, pt, pr);
    check_eq("n5_clk", pc, 32'b1100011000);
    check_eq("n5_tick", pt, 32'b1000010000);
    check_eq("n5_cur_div", 32'(cur_div), 32'd5);

    // N=10, load 3 at cnt=4: current period completes, next is 1 high / 2 low.
    run(3, 1'b0);
    cycle(1'b0, 1'b1, 16'd10);
    collect(16, '1, 5, 16'd3, pc, pt, pr);
    check_eq("mid_load_clk", pc, 32'b1111100000100100);
    check_eq("mid_load_cur_div", 32'(cur_div), 32'd3);

    // Load 3 exactly at cnt=9 of an N=10 period applies to the very next period.
    cycle(1'b1, 1'b1, 16'd10);
    run(9, 1'b1);
    collect(6, '1, 0, 16'd3, pc, pt, pr);
    check_eq("last_load_clk", pc, 32'b100100);
    check_eq("last_load_cur_div", 32'(cur_div), 32'd3);

    // Clamp: 0 and 1 both become 2.
    collect(6, '1, 0, 16'd0, pc, pt, pr);
    check_eq("clamp0_clk", pc, 32'b101010);
    check_eq("clamp0_tick", pt, 32'b101010);
    check_eq("clamp0_cur_div", 32'(cur_div), 32'd2);
    collect(4, '1, 0, 16'd1, pc, pt, pr);
    check_eq("clamp1_clk", pc, 32'b1010);
    check_eq("clamp1_cur_div", 32'(cur_div), 32'd2);

    // Clean stop at N=8: en drops at cnt=1, returns during DRAIN; drain still finishes.
    collect(10, 32'b1100111111, 0, 16'd8, pc, pt, pr);
    check_eq("stop_clk", pc, 32'b1111000001);
    check_eq("stop_running", pr, 32'b1111111101);

    // Async reset in the high phase of an N=6 period.
    cycle(1'b1, 1'b1, 16'd6);
    run(8, 1'b1);
    @(negedge clk_in);
    #1;
    check_eq("pre_rst_clk_out", 32'(clk_out), 32'd1);
    check_eq("pre_rst_cur_div", 32'(cur_div), 32'd6);
    rst_n = 1'b0;
    #1;
    check_eq("async_clk_out", 32'(clk_out), 32'd0);
    check_eq("async_tick", 32'(tick), 32'd0);
    check_eq("async_running", 32'(running), 32'd0);
    check_eq("async_cur_div", 32'(cur_div), 32'd4);
    model_reset();
    #10;
    rst_n = 1'b1;
    collect(8, '1, -1, '0, pc, pt, pr);
    check_eq("post_rst_clk", pc, 32'b11001100);
    check_eq("post_rst_cur_div", 32'(cur_div), 32'd4);

    en = 1'b0;
    @(negedge clk_in);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Runtime-programmable, glitch-free successor to the fixed divide-by-4 (100 MHz to 25 MHz) clock divider.
- Divides clk_in by any integer N from 2 to 2^CNT_W-1.
- Supports clean start/stop through an enable and divisor changes only at period boundaries.
- Produces a registered divided clock plus a single-cycle tick strobe, for use as a clock enable by downstream logic such as debouncers and display scanners in the clk_in domain.

Parameters:
- CNT_W, 16, width of the divisor and the internal period counter.
- DEFAULT_DIV, 4, divisor loaded at reset. Must be in the range 2..2^CNT_W-1.

Ports:
- clk_in, input, 1, system clock (100 MHz on the board).
- rst_n, input, 1, asynchronous, active-low reset.
- en, input, 1, run request. 1 means run. 0 means stop cleanly at the end of the current period.
- load, input, 1, single-cycle strobe that captures div_val.
- div_val, input, CNT_W, requested divisor N.
- clk_out, output, 1, divided clock, registered.
- tick, output, 1, one clk_in-cycle pulse coincident with each rising edge of clk_out.
- cur_div, output, CNT_W, divisor currently in effect.
- running, output, 1, high while in RUN or DRAIN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, cnt=0, clk_out=0, tick=0, running=0.
  - pend_div=DEFAULT_DIV, cur_div=DEFAULT_DIV.
- Clamp: any captured div_val below 2 (0 or 1) is stored as 2. No other saturation applies.
- Load handling:
  - On an edge with load=1, pend_div <= clamp(div_val).
  - Define nd = load ? clamp(div_val) : pend_div. This is the value taken at any period start on that same edge (bypass).
- Period shape for N=cur_div and H=floor(N/2):
  - cnt runs 0..N-1, then wraps to 0.
  - clk_out=1 for cnt 0..H-1 and clk_out=0 for cnt H..N-1.
  - This gives H cycles high and N-H cycles low. N=4 gives 2 high / 2 low. N=5 gives 2 high / 3 low.
- Outputs are registered: clk_out and tick reflect the cnt value written on the same edge.
- State machine, with all transitions on the posedge of clk_in:
  - IDLE, en=0: hold. clk_out=0, tick=0, cnt=0.
  - IDLE, en=1: go to RUN. cnt<=0, clk_out<=1, tick<=1, cur_div<=nd. The first rising edge of clk_out is one clk_in cycle after en is sampled.
  - RUN:
    - cnt<=cnt+1.
    - clk_out<=0 when cnt+1==H.
    - tick<=0.
    - At cnt==N-1 (period boundary): if en=1, cnt<=0, clk_out<=1, tick<=1, cur_div<=nd. If en=0, go to IDLE with clk_out=0.
    - If en drops mid-period (cnt<N-1), go to DRAIN.
  - DRAIN: continue the current period unchanged. At cnt==N-1 go to IDLE, regardless of en. Re-asserting en during DRAIN does not abort the drain; the block restarts from IDLE on the next en=1 edge.
- Glitch freedom:
  - cur_div never changes mid-period.
  - clk_out never produces a high or low phase shorter than floor(cur_div/2) cycles.
  - Stopping never truncates a high phase.
- N=2: clk_out toggles every cycle and tick fires every 2nd cycle.
- Reset mid-operation: clk_out drops to 0 immediately (asynchronous) and all state returns to reset values. There is no drain.
- running is 1 in RUN and DRAIN, and 0 in IDLE.

Decomposition:
- Package clock_div_pkg:
  - State enum {IDLE, RUN, DRAIN}.
  - Constant MIN_DIV=2.
  - Function clamp_div(v), which returns v<MIN_DIV ? MIN_DIV : v.
- No sub-module. The counter, FSM and divisor registers form one block.

Test Plan:
- Reset defaults, en=1 with no load: clk_out period of 4 cycles at 2 high / 2 low, matching the 100 MHz to 25 MHz case. tick every 4th cycle, cur_div=4. First rising edge of clk_out appears 1 cycle after en is sampled.
- Odd divisor: load div_val=5 while IDLE, then en=1: clk_out runs 2 high / 3 low repeatedly, with tick spacing of 5 and cur_div=5.
- Mid-period change: running at N=10, load div_val=3 at cnt=4. The current period completes as 5 high / 5 low; the next period is 1 high / 2 low. load asserted exactly at cnt=9 also applies N=3 to the very next period.
- Clamp: load div_val=0, then load div_val=1. Each time cur_div=2 at the next boundary and clk_out toggles every cycle.
- Clean stop: at N=8, drop en at cnt=1. The period completes (4 high / 4 low), running is 1 through DRAIN, then IDLE with clk_out=0. Re-asserting en during DRAIN does not restart the divider before IDLE is reached.
- Async reset: assert rst_n=0 mid high phase at N=6, between clk edges. clk_out, tick and running go to 0 immediately and cur_div=4. After release with en=1, normal operation resumes at N=4.
